// File: rtl/atomik_txn_arbiter.sv
// Two-requester burst arbiter in front of a shared scramble core.
// Round-robin grant, contiguous-beat forwarding, abort on stall/timeout, forced idle gap between bursts.
module atomik_txn_arbiter #(
   parameter int unsigned GAP_CYCLES = 1,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_a,
   input  logic        req_b,
   input  logic [7:0]  len_a,
   input  logic [7:0]  len_b,
   input  logic [31:0] din_a,
   input  logic [31:0] din_b,
   input  logic        dv_a,
   input  logic        dv_b,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic [31:0] dout_a,
   output logic [31:0] dout_b,
   output logic        drdy_a,
   output logic        drdy_b,
   output logic [31:0] core_din,
   output logic        core_dv,
   input  logic [31:0] core_dout,
   input  logic        core_drdy,
   output logic        busy,
   output logic        owner,
   output logic        abort
);

   // state  | meaning
   // IDLE   | no burst; arbitrate on req_a/req_b
   // GRANT  | owner granted, waiting (bounded) for first beat
   // STREAM | forwarding contiguous beats to the core
   // GAP    | forced core_dv-low interval before next arbitration
   typedef enum logic [1:0] {IDLE, GRANT, STREAM, GAP} state_t;

   localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);
   localparam logic [3:0] GAP_L     = 4'(GAP_CYCLES);

   state_t      state_q;
   state_t      state_nxt;
   logic        owner_nxt;
   logic [8:0]  len_q;
   logic [8:0]  len_nxt;
   logic [8:0]  beat_q;
   logic [8:0]  beat_nxt;
   logic [7:0]  wait_q;
   logic [7:0]  wait_nxt;
   logic [3:0]  gap_q;
   logic [3:0]  gap_nxt;
   logic        rr_b_q;
   logic        rr_b_nxt;
   logic        core_dv_nxt;
   logic [31:0] core_din_nxt;
   logic        abort_nxt;
   logic        win_b;
   logic [7:0]  len_win;
   logic        dv_own;
   logic [31:0] din_own;
   logic        granted_nxt;

   assign dv_own  = owner ? dv_b : dv_a;
   assign din_own = owner ? din_b : din_a;

   always_comb begin
      state_nxt    = state_q;
      owner_nxt    = owner;
      len_nxt      = len_q;
      beat_nxt     = beat_q;
      wait_nxt     = wait_q;
      gap_nxt      = gap_q;
      rr_b_nxt     = rr_b_q;
      core_dv_nxt  = 1'b0;
      core_din_nxt = core_din;
      abort_nxt    = 1'b0;
      win_b        = req_b & (~req_a | rr_b_q);
      len_win      = win_b ? len_b : len_a;

      case (state_q)
         IDLE: begin
            if (req_a || req_b) begin
               state_nxt = GRANT;
               owner_nxt = win_b;
               rr_b_nxt  = ~win_b;
               len_nxt   = (len_win == 8'd0) ? 9'd256 : {1'b0, len_win};
               beat_nxt  = 9'd0;
               wait_nxt  = TIMEOUT_L;
            end
         end
         GRANT: begin
            if (dv_own) begin
               core_dv_nxt  = 1'b1;
               core_din_nxt = din_own;
               beat_nxt     = 9'd1;
               if (len_q == 9'd1) begin
                  state_nxt = GAP;
                  gap_nxt   = GAP_L;
               end else begin
                  state_nxt = STREAM;
               end
            end else if (wait_q <= 8'd1) begin
               abort_nxt = 1'b1;
               state_nxt = GAP;
               gap_nxt   = GAP_L;
            end else begin
               wait_nxt = wait_q - 8'd1;
            end
         end
         STREAM: begin
            if (dv_own) begin
               core_dv_nxt  = 1'b1;
               core_din_nxt = din_own;
               beat_nxt     = beat_q + 9'd1;
               if (beat_q + 9'd1 == len_q) begin
                  state_nxt = GAP;
                  gap_nxt   = GAP_L;
               end
            end else begin
               // a stalled beat breaks contiguity: the burst is dropped
               abort_nxt = 1'b1;
               state_nxt = GAP;
               gap_nxt   = GAP_L;
            end
         end
         GAP: begin
            if (gap_q <= 4'd1) begin
               state_nxt = IDLE;
            end else begin
               gap_nxt = gap_q - 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign granted_nxt = (state_nxt == GRANT) || (state_nxt == STREAM);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner    <= 1'b0;
         len_q    <= 9'd0;
         beat_q   <= 9'd0;
         wait_q   <= 8'd0;
         gap_q    <= 4'd0;
         rr_b_q   <= 1'b0;
         core_dv  <= 1'b0;
         core_din <= 32'd0;
         abort    <= 1'b0;
         gnt_a    <= 1'b0;
         gnt_b    <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_nxt;
         owner    <= owner_nxt;
         len_q    <= len_nxt;
         beat_q   <= beat_nxt;
         wait_q   <= wait_nxt;
         gap_q    <= gap_nxt;
         rr_b_q   <= rr_b_nxt;
         core_dv  <= core_dv_nxt;
         core_din <= core_din_nxt;
         abort    <= abort_nxt;
         gnt_a    <= granted_nxt & ~owner_nxt;
         gnt_b    <= granted_nxt & owner_nxt;
         busy     <= (state_nxt != IDLE);
      end
   end

   // owner is frozen through GAP so the trailing core result still routes home
   assign drdy_a = core_drdy && !owner && (state_q == STREAM || state_q == GAP);
   assign drdy_b = core_drdy &&  owner && (state_q == STREAM || state_q == GAP);
   assign dout_a = owner ? 32'd0 : core_dout;
   assign dout_b = owner ? core_dout : 32'd0;

endmodule

// File: tb/tb_atomik_txn_arbiter.sv
// Self-checking bench for atomik_txn_arbiter: table of bursts plus a reset-mid-burst sequence.
// A zero-latency XOR core model answers every core_dv beat in the same cycle.
module tb_atomik_txn_arbiter;

   localparam int          PERIOD = 10;
   localparam int          GAP    = 1;
   localparam int          TO     = 16;
   localparam logic [31:0] KEY    = 32'hA5A5_5A5A;

   logic        clk;
   logic        rst_n;
   logic        req_a, req_b;
   logic [7:0]  len_a, len_b;
   logic [31:0] din_a, din_b;
   logic        dv_a, dv_b;
   logic        gnt_a, gnt_b;
   logic [31:0] dout_a, dout_b;
   logic        drdy_a, drdy_b;
   logic [31:0] core_din;
   logic        core_dv;
   logic [31:0] core_dout;
   logic        core_drdy;
   logic        busy, owner, abort;

   atomik_txn_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .req_b(req_b), .len_a(len_a), .len_b(len_b),
      .din_a(din_a), .din_b(din_b), .dv_a(dv_a), .dv_b(dv_b),
      .gnt_a(gnt_a), .gnt_b(gnt_b), .dout_a(dout_a), .dout_b(dout_b),
      .drdy_a(drdy_a), .drdy_b(drdy_b),
      .core_din(core_din), .core_dv(core_dv), .core_dout(core_dout), .core_drdy(core_drdy),
      .busy(busy), .owner(owner), .abort(abort)
   );

   assign core_dout = core_din ^ KEY;
   assign core_drdy = core_dv;

   initial clk = 1'b0;
   always #(PERIOD/2) clk = ~clk;

   typedef struct {
      bit         ra;
      bit         rb;
      logic [7:0] la;
      logic [7:0] lb;
      int         nd;
      bit         own;
   } burst_t;

   typedef struct {
      logic [1:0]  port;
      logic [31:0] data;
   } res_t;

   int   checks = 0;
   int   passed = 0;
   res_t exp_q[$];
   int   obs_rd = 0;

   // monitor state (written only by the monitor)
   int          n_cdv = 0, n_abort = 0, n_gnt = 0, n_both = 0;
   int          low_run = 1000, last_low = 1000;
   time         last_rise = 0;
   logic        prev_dv = 1'b0;
   logic [31:0] obs_data [1024];
   logic [1:0]  obs_port [1024];
   int          obs_wr = 0;

   always @(negedge clk) begin
      if (core_dv)        n_cdv   <= n_cdv + 1;
      if (abort)          n_abort <= n_abort + 1;
      if (gnt_a || gnt_b) n_gnt   <= n_gnt + 1;
      if (gnt_a && gnt_b) n_both  <= n_both + 1;
      if (core_dv) begin
         if (!prev_dv) begin
            last_low  <= low_run;
            last_rise <= $time;
         end
         low_run <= 0;
      end else begin
         low_run <= low_run + 1;
      end
      prev_dv <= core_dv;
      if (drdy_a || drdy_b) begin
         obs_port[obs_wr % 1024] <= {drdy_b, drdy_a};
         obs_data[obs_wr % 1024] <= drdy_a ? dout_a : dout_b;
         obs_wr <= obs_wr + 1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n = 0;
      while (busy && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk(name, busy, 0);
   endtask

   task automatic run_burst(input int idx, input burst_t v);
      int          len_eff, fwd, exp_gnt, s_cdv, s_ab, s_gn, s_both;
      time         t_req;
      logic [7:0]  l;
      logic [31:0] base;
      res_t        r;

      wait_idle($sformatf("b%0d_idle_before", idx), 400);
      s_cdv = n_cdv; s_ab = n_abort; s_gn = n_gnt; s_both = n_both;
      req_a = v.ra; req_b = v.rb; len_a = v.la; len_b = v.lb;
      t_req = $time;
      @(negedge clk);
      req_a = 1'b0; req_b = 1'b0;
      chk($sformatf("b%0d_grant", idx), {gnt_a, gnt_b, owner}, {~v.own, v.own, v.own});

      l       = v.own ? v.lb : v.la;
      len_eff = (l == 8'd0) ? 256 : int'(l);
      fwd     = (v.nd < len_eff) ? v.nd : len_eff;
      exp_gnt = (v.nd == 0) ? TO : ((v.nd >= len_eff) ? len_eff : v.nd + 1);
      base    = (idx == 4) ? 32'd1 : ((idx << 16) | 1);

      // the non-owner keeps presenting junk beats throughout
      if (v.own) begin dv_a = 1'b1; din_a = 32'hDEAD_0000; end
      else       begin dv_b = 1'b1; din_b = 32'hDEAD_0000; end
      for (int i = 0; i < v.nd; i++) begin
         if (v.own) begin dv_b = 1'b1; din_b = base + i; end
         else       begin dv_a = 1'b1; din_a = base + i; end
         if (i < len_eff) begin
            r.port = v.own ? 2'b10 : 2'b01;
            r.data = (base + i) ^ KEY;
            exp_q.push_back(r);
         end
         @(negedge clk);
      end
      if (v.own) dv_b = 1'b0; else dv_a = 1'b0;

      wait_idle($sformatf("b%0d_idle_after", idx), TO + 300);
      dv_a = 1'b0; dv_b = 1'b0;
      @(negedge clk);

      chk($sformatf("b%0d_core_dv_cycles", idx), n_cdv - s_cdv, fwd);
      chk($sformatf("b%0d_abort_pulses", idx), n_abort - s_ab, (fwd < len_eff) ? 1 : 0);
      chk($sformatf("b%0d_gnt_cycles", idx), n_gnt - s_gn, exp_gnt);
      chk($sformatf("b%0d_both_gnt", idx), n_both - s_both, 0);
      if (fwd > 0) begin
         chk($sformatf("b%0d_latency", idx), (last_rise - t_req) / PERIOD, 2);
         chk($sformatf("b%0d_gap_before", idx), last_low >= GAP, 1);
      end
      while (exp_q.size() > 0) begin
         r = exp_q.pop_front();
         if (obs_rd >= obs_wr) begin
            chk($sformatf("b%0d_result_missing", idx), exp_q.size() + 1, 0);
            exp_q.delete();
         end else begin
            chk($sformatf("b%0d_result_port", idx), obs_port[obs_rd % 1024], r.port);
            chk($sformatf("b%0d_result_data", idx), obs_data[obs_rd % 1024], r.data);
            obs_rd++;
         end
      end
      chk($sformatf("b%0d_extra_results", idx), obs_wr - obs_rd, 0);
   endtask

   burst_t vec [11];

   initial begin
      burst_t t;
      vec[0]  = '{ra:1, rb:1, la:8'd1, lb:8'd1, nd:1,   own:0};
      vec[1]  = '{ra:1, rb:1, la:8'd1, lb:8'd1, nd:1,   own:1};
      vec[2]  = '{ra:1, rb:1, la:8'd1, lb:8'd1, nd:1,   own:0};
      vec[3]  = '{ra:1, rb:1, la:8'd1, lb:8'd1, nd:1,   own:1};
      vec[4]  = '{ra:1, rb:0, la:8'd4, lb:8'd9, nd:4,   own:0};
      vec[5]  = '{ra:0, rb:1, la:8'd7, lb:8'd0, nd:256, own:1};
      vec[6]  = '{ra:1, rb:0, la:8'd8, lb:8'd3, nd:2,   own:0};
      vec[7]  = '{ra:1, rb:0, la:8'd5, lb:8'd5, nd:0,   own:0};
      vec[8]  = '{ra:1, rb:0, la:8'd3, lb:8'd3, nd:3,   own:0};
      vec[9]  = '{ra:0, rb:1, la:8'd3, lb:8'd2, nd:2,   own:1};
      vec[10] = '{ra:1, rb:1, la:8'd2, lb:8'd2, nd:2,   own:0};

      rst_n = 1'b0;
      req_a = 1'b0; req_b = 1'b0; len_a = 8'd0; len_b = 8'd0;
      din_a = 32'd0; din_b = 32'd0; dv_a = 1'b0; dv_b = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_state", {gnt_a, gnt_b, core_dv, abort, owner, busy, drdy_a, drdy_b, core_din},
          {8'd0, 32'd0});
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) run_burst(i, vec[i]);

      // reset in the middle of a burst: grant and core_dv drop, no abort
      wait_idle("rst_idle_before", 400);
      req_a = 1'b1; len_a = 8'd8;
      @(negedge clk);
      req_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         dv_a  = 1'b1;
         din_a = 32'h7700_0000 + i;
         if (i == 2) rst_n = 1'b0;
         @(negedge clk);
      end
      chk("rst_mid_outputs", {gnt_a, gnt_b, core_dv, busy, abort, owner}, 6'd0);
      @(negedge clk);
      chk("rst_mid_no_abort", abort, 1'b0);
      rst_n = 1'b1;
      dv_a  = 1'b0;
      @(negedge clk);
      obs_rd = obs_wr;
      exp_q.delete();

      // round-robin pointer must be back to preferring A
      t = '{ra:1, rb:1, la:8'd1, lb:8'd1, nd:1, own:0};
      run_burst(11, t);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/atomik_txn_arbiter.md
ATOMIK_TXN_ARBITER -- requirements
Module: atomik_txn_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 1, idle cycles forced on core_dv between bursts (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 16, max cycles from grant to first beat (legal range 1..255).
REQ-003 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: req_a / req_b  in  1  burst request per requester.
REQ-005 SHALL have ports: len_a / len_b  in  8  burst length in beats; 0 encodes 256.
REQ-006 SHALL have ports: din_a / din_b  in  32  beat data; dv_a / dv_b  in  1  beat valid.
REQ-007 SHALL have ports: gnt_a / gnt_b  out  1  grant; dout_a / dout_b  out  32  scrambled result; drdy_a / drdy_b  out  1  result valid.
REQ-008 SHALL have ports: core_din  out  32; core_dv  out  1; core_dout  in  32; core_drdy  in  1  (scramble-core data port).
REQ-009 SHALL have ports: busy  out  1  state != IDLE; owner  out  1  0=A, 1=B; abort  out  1  one-cycle burst-abort pulse.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT, STREAM, GAP; all outputs except dout_x/drdy_x registered.
REQ-011 IDLE: req_a or req_b high -> GRANT next cycle; owner latched; len of winner latched into 9-bit len_q (0 -> 256).
REQ-012 Arbitration SHALL be round-robin: both requesting -> requester not granted last wins; after reset A wins a tie.
REQ-013 gnt_x SHALL be high exactly while state is GRANT or STREAM and owner==x; other gnt always 0.
REQ-014 GRANT: dv_owner high -> core_din<=din_owner, core_dv<=1, beat_cnt<=1; next state STREAM, or GAP if len_q==1.
REQ-015 GRANT: wait counter counts cycles with dv_owner low; reaching TIMEOUT -> abort pulse, go to GAP, core_dv stays 0.
REQ-016 STREAM: each cycle dv_owner high -> forward beat to core (registered, 1-cycle latency), beat_cnt+1; beat making beat_cnt==len_q -> GAP next cycle.
REQ-017 STREAM: dv_owner low -> core_dv<=0, abort pulse, go to GAP; beats SHALL be contiguous (no stalls mid-burst).
REQ-018 core_dv SHALL be 0 in IDLE and GAP and for any non-forwarded cycle; core_din holds last value when core_dv=0.
REQ-019 GAP: lasts exactly GAP_CYCLES cycles, then IDLE; guarantees a core_dv falling edge between bursts (core end-of-transaction / OTP seed rotation).
REQ-020 Result routing (combinational): drdy_x = core_drdy && owner==x && state in {STREAM, GAP}; dout_x = core_dout when owner==x, else 0.
REQ-021 owner SHALL remain stable from GRANT entry until IDLE re-entry so the last core result (one cycle after last core_dv) reaches the correct requester.
REQ-022 Requests arriving outside IDLE SHALL be ignored until IDLE; req_x drop during GRANT/STREAM SHALL NOT terminate the burst.
REQ-023 dv of non-owner SHALL be ignored; beat counter 9 bits, no wrap (max 256).
REQ-024 Minimum request-to-first-core_dv latency SHALL be 2 cycles (IDLE->GRANT, GRANT forwards).

Reset
REQ-025 rst_n low at a clock edge: state IDLE, gnt_a/b=0, core_dv=0, core_din=0, abort=0, owner=0, RR pointer prefers A, counters 0.
REQ-026 Reset mid-burst SHALL drop core_dv and gnt the next edge; no abort pulse generated by reset.

Verification
REQ-027 req_a, len_a=4, dv_a high 4 cycles with din 1..4 -> core_dv high exactly 4 cycles, data 1..4, drdy_a 4 results, then GAP_CYCLES idle cycles, busy low.
REQ-028 req_a and req_b together repeatedly, len=1 -> grants alternate A,B,A,B; never both gnt high.
REQ-029 req_b, len_b=0, 256 contiguous beats -> 256 core_dv cycles, then GAP; beat_cnt no overflow.
REQ-030 req_a granted, dv_a never asserted -> abort pulse after 16 cycles in GRANT, zero core_dv, return to IDLE after GAP.
REQ-031 len_a=8, dv_a low on beat 3 -> core_dv high 2 cycles then low, abort pulse, drdy_a only for 2 results.
REQ-032 Back-to-back bursts A then B -> core_dv low ≥ GAP_CYCLES between them; last A result on drdy_a, never on drdy_b.
